// File: rtl/key_rotation_ctrl_pkg.sv
// Shared types and widths for the key rotation controller.
// The StError state is only present when KEYROT_TIMEOUT_EN is defined.
package key_rotation_ctrl_pkg;

  localparam int unsigned AES_KEY_W = 128;
  localparam int unsigned CRC_KEY_W = 16;
  localparam int unsigned EPOCH_W   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitKey,
`ifdef KEYROT_TIMEOUT_EN
    StActive,
    StError
`else
    StActive
`endif
  } state_e;

endpackage

// File: rtl/key_rotation_ctrl.sv
// Key rotation controller: requests keys, latches them atomically, rekeys every REKEY_FRAMES.
// Optional key-generator timeout with sticky error state: define KEYROT_TIMEOUT_EN.
module key_rotation_ctrl
  import key_rotation_ctrl_pkg::*;
#(
  parameter int unsigned REKEY_FRAMES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 frame_done,
  output logic                 kg_generate_key,
  input  logic                 kg_key_valid,
  input  logic                 kg_busy,
  input  logic [AES_KEY_W-1:0] kg_aes_key,
  input  logic [CRC_KEY_W-1:0] kg_crc_key,
  output logic [AES_KEY_W-1:0] aes_key,
  output logic [CRC_KEY_W-1:0] crc_key,
  output logic                 key_ready,
  output logic                 rekey_pending,
  output logic [EPOCH_W-1:0]   key_epoch,
  output logic                 timeout_err
);

  localparam int unsigned FrameW = (REKEY_FRAMES > 1) ? $clog2(REKEY_FRAMES) : 1;

  if (REKEY_FRAMES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("REKEY_FRAMES and TIMEOUT_CYCLES must both be at least 1");
  end

  state_e              state_q;
  logic                valid_q;
  logic [FrameW-1:0]   frame_cnt_q;
  logic                key_edge;

  // Only a fresh 0->1 transition latches; a level left over from a prior request does not.
  assign key_edge = kg_key_valid & ~valid_q;

`ifdef KEYROT_TIMEOUT_EN
  localparam int unsigned WaitW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WaitW-1:0] wait_cnt_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      valid_q         <= 1'b0;
      frame_cnt_q     <= '0;
      kg_generate_key <= 1'b0;
      aes_key         <= '0;
      crc_key         <= '0;
      key_ready       <= 1'b0;
      rekey_pending   <= 1'b0;
      key_epoch       <= '0;
`ifdef KEYROT_TIMEOUT_EN
      wait_cnt_q      <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      valid_q         <= kg_key_valid;
      kg_generate_key <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) state_q <= StReq;
        end
        StReq: begin
          // Hold the request until the generator is free.
          if (!kg_busy) begin
            kg_generate_key <= 1'b1;
            state_q         <= StWaitKey;
`ifdef KEYROT_TIMEOUT_EN
            wait_cnt_q      <= '0;
`endif
          end
        end
        StWaitKey: begin
          if (key_edge) begin
            aes_key       <= kg_aes_key;
            crc_key       <= kg_crc_key;
            key_epoch     <= key_epoch + 1'b1;
            key_ready     <= 1'b1;
            rekey_pending <= 1'b0;
            frame_cnt_q   <= '0;
            state_q       <= StActive;
          end
`ifdef KEYROT_TIMEOUT_EN
          else if (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err   <= 1'b1;
            key_ready     <= 1'b0;
            rekey_pending <= 1'b0;
            aes_key       <= '0;
            crc_key       <= '0;
            state_q       <= StError;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        StActive: begin
          if (frame_done) begin
            if (frame_cnt_q == FrameW'(REKEY_FRAMES - 1)) begin
              frame_cnt_q   <= '0;
              rekey_pending <= 1'b1;
              state_q       <= StReq;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
`ifdef KEYROT_TIMEOUT_EN
        StError: begin
          if (start) state_q <= StReq;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
